rtcomp_pipe: RTL and testbench

- Parametrised, registered route-computation stage for the 5-port mesh router; sits between an input-VC buffer and switch/VC allocation.
- Decodes the destination from each head flit, computes the output port under a selectable routing mode (XY, YX, west-first adaptive) and latches it for the rest of the packet.
- Body and tail flits reuse the latched route.
- Valid/ready handshake, one-cycle latency.

---
 rtl/rtcomp_pipe.sv | 147 ++++++++++++++
 tb/tb_rtcomp_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rtcomp_pipe.sv
// Registered route-computation stage for a 5-port mesh router.
// Head flits compute and latch an output port; body/tail flits reuse it.
module rtcomp_pipe #(
  parameter int unsigned ARRAYW     = 4,
  parameter int unsigned ADDRW      = 16,
  parameter int unsigned DSTX_LSB   = 0,
  parameter int unsigned DSTY_LSB   = 4,
  parameter int unsigned VCHW       = 1,
  parameter int unsigned ROUTE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ARRAYW-1:0] my_xpos,
  input  logic [ARRAYW-1:0] my_ypos,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic [ADDRW-1:0]  addr,
  input  logic [VCHW:0]     ivch,
  input  logic [4:0]        cong,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        port,
  output logic [VCHW:0]     ovch,
  output logic              out_tail,
  output logic              err
);

  localparam logic [2:0] P_YM  = 3'd0;
  localparam logic [2:0] P_XP  = 3'd1;
  localparam logic [2:0] P_YP  = 3'd2;
  localparam logic [2:0] P_XM  = 3'd3;
  localparam logic [2:0] P_LOC = 3'd4;

  typedef enum logic [0:0] {IDLE, PKT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         route_q, route_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         port_q, port_d;
  logic [VCHW:0]      ovch_q, ovch_d;
  logic               out_tail_q, out_tail_d;
  logic               err_q, err_d;

  logic [ARRAYW-1:0]  dst_x, dst_y;
  logic               xp, xm, yp, ym, cong_y, accept;
  logic [2:0]         route_c, ycode;
  logic               unused_addr_c;

  assign dst_x         = addr[DSTX_LSB +: ARRAYW];
  assign dst_y         = addr[DSTY_LSB +: ARRAYW];
  assign unused_addr_c = ^addr;

  assign xp = dst_x > my_xpos;
  assign xm = dst_x < my_xpos;
  assign yp = dst_y > my_ypos;
  assign ym = dst_y < my_ypos;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output-port selection; unknown modes fall back to dimension-order XY.
  always_comb begin
    route_c = P_LOC;
    ycode   = yp ? P_YP : P_YM;
    cong_y  = yp ? cong[2] : cong[0];
    if (!(xp || xm || yp || ym)) begin
      route_c = P_LOC;
    end else if (ROUTE_MODE == 1) begin
      if (yp)      route_c = P_YP;
      else if (ym) route_c = P_YM;
      else if (xp) route_c = P_XP;
      else         route_c = P_XM;
    end else if (ROUTE_MODE == 2) begin
      if (xm) begin
        route_c = P_XM;
      end else if (xp && (yp || ym)) begin
        // Two productive choices: avoid a congested X+ only if Y is free.
        route_c = (cong[1] && !cong_y) ? ycode : P_XP;
      end else if (xp) begin
        route_c = P_XP;
      end else begin
        route_c = ycode;
      end
    end else begin
      if (xp)      route_c = P_XP;
      else if (xm) route_c = P_XM;
      else if (yp) route_c = P_YP;
      else         route_c = P_YM;
    end
  end

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    out_valid_d = out_valid_q;
    port_d      = port_q;
    ovch_d      = ovch_q;
    out_tail_d  = out_tail_q;
    err_d       = err_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      ovch_d      = ivch;
      out_tail_d  = in_tail;
      if (in_head) begin
        route_d = route_c;
        port_d  = route_c;
        state_d = in_tail ? IDLE : PKT;
        if (state_q == PKT) err_d = 1'b1;
      end else begin
        port_d = route_q;
        if (state_q == IDLE)  err_d   = 1'b1;
        else if (in_tail)     state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      route_q     <= 3'd0;
      out_valid_q <= 1'b0;
      port_q      <= 3'd0;
      ovch_q      <= '0;
      out_tail_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      out_valid_q <= out_valid_d;
      port_q      <= port_d;
      ovch_q      <= ovch_d;
      out_tail_q  <= out_tail_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign port      = port_q;
  assign ovch      = ovch_q;
  assign out_tail  = out_tail_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtcomp_pipe.sv
// Directed bench for rtcomp_pipe: one instance per routing mode, shared stimulus.
module tb_rtcomp_pipe;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  my_xpos, my_ypos;
  logic        in_valid, in_head, in_tail, out_ready;
  logic [15:0] addr;
  logic [1:0]  ivch;
  logic [4:0]  cong;

  logic        rdy_xy, rdy_yx, rdy_wf;
  logic        ov_xy, ov_yx, ov_wf;
  logic [2:0]  port_xy, port_yx, port_wf;
  logic [1:0]  ovch_xy, ovch_yx, ovch_wf;
  logic        ot_xy, ot_yx, ot_wf;
  logic        err_xy, err_yx, err_wf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtcomp_pipe #(.ROUTE_MODE(0)) u_xy (
    .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .in_valid(in_valid), .in_ready(rdy_xy), .in_head(in_head), .in_tail(in_tail),
    .addr(addr), .ivch(ivch), .cong(cong), .out_valid(ov_xy), .out_ready(out_ready),
    .port(port_xy), .ovch(ovch_xy), .out_tail(ot_xy), .err(err_xy));

  rtcomp_pipe #(.ROUTE_MODE(1)) u_yx (
    .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .in_valid(in_valid), .in_ready(rdy_yx), .in_head(in_head), .in_tail(in_tail),
    .addr(addr), .ivch(ivch), .cong(cong), .out_valid(ov_yx), .out_ready(out_ready),
    .port(port_yx), .ovch(ovch_yx), .out_tail(ot_yx), .err(err_yx));

  rtcomp_pipe #(.ROUTE_MODE(2)) u_wf (
    .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .in_valid(in_valid), .in_ready(rdy_wf), .in_head(in_head), .in_tail(in_tail),
    .addr(addr), .ivch(ivch), .cong(cong), .out_valid(ov_wf), .out_ready(out_ready),
    .port(port_wf), .ovch(ovch_wf), .out_tail(ot_wf), .err(err_wf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one flit for a single accepting edge, then sample just after it.
  task automatic send(input logic h, input logic t, input logic [15:0] a, input logic [1:0] vc);
    in_head  = h;
    in_tail  = t;
    addr     = a;
    ivch     = vc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; my_xpos = 4'd2; my_ypos = 4'd2;
    in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; out_ready = 1'b1;
    addr = 16'h0; ivch = 2'd0; cong = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ov_xy), 32'd0);
    check("rst_port",  32'(port_xy), 32'd0);
    check("rst_err",   32'(err_xy), 32'd0);
    check("rst_ready", 32'(rdy_xy), 32'd1);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Single-flit packets, my = (2,2); addr = {.., y, x}
    send(1'b1, 1'b1, 16'h0015, 2'd0);
    check("xy_51_valid", 32'(ov_xy), 32'd1);
    check("xy_51_port",  32'(port_xy), 32'd1);
    check("yx_51_port",  32'(port_yx), 32'd0);
    send(1'b1, 1'b1, 16'h0042, 2'd0);
    check("xy_24_port",  32'(port_xy), 32'd2);
    send(1'b1, 1'b1, 16'h0022, 2'd0);
    check("xy_22_port",  32'(port_xy), 32'd4);
    check("yx_22_port",  32'(port_yx), 32'd4);
    check("wf_22_port",  32'(port_wf), 32'd4);
    send(1'b1, 1'b1, 16'h0030, 2'd0);
    check("xy_03_port",  32'(port_xy), 32'd3);
    send(1'b1, 1'b1, 16'h0051, 2'd0);
    check("wf_15_port",  32'(port_wf), 32'd3);
    @(posedge clk); #1;
    check("idle_valid", 32'(ov_xy), 32'd0);

    // West-first adaptive choice driven by congestion at head time
    cong = 5'b00010;
    send(1'b1, 1'b1, 16'h0044, 2'd0);
    check("wf_cong_port", 32'(port_wf), 32'd2);
    cong = 5'b00000;
    send(1'b1, 1'b0, 16'h0044, 2'd0);
    check("wf_free_port", 32'(port_wf), 32'd1);
    cong = 5'b00010;
    send(1'b0, 1'b0, 16'h0000, 2'd0);
    check("wf_body1_port", 32'(port_wf), 32'd1);
    cong = 5'b00101;
    send(1'b0, 1'b1, 16'h0000, 2'd0);
    check("wf_tail_port", 32'(port_wf), 32'd1);
    check("wf_tail_flag", 32'(ot_wf), 32'd1);
    cong = 5'b00000;

    // 4-flit packet on ivch 1 with a two-cycle downstream stall on flit 2
    send(1'b1, 1'b0, 16'h0015, 2'd1);
    check("pk_head_port", 32'(port_xy), 32'd1);
    check("pk_head_ovch", 32'(ovch_xy), 32'd1);
    send(1'b0, 1'b0, 16'h0000, 2'd1);
    check("pk_b1_port", 32'(port_xy), 32'd1);
    out_ready = 1'b0;
    in_head = 1'b0; in_tail = 1'b0; addr = 16'h0000; ivch = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stall_ready", 32'(rdy_xy), 32'd0);
      check("stall_valid", 32'(ov_xy), 32'd1);
      check("stall_port",  32'(port_xy), 32'd1);
      check("stall_ovch",  32'(ovch_xy), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(rdy_xy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pk_b2_port", 32'(port_xy), 32'd1);
    check("pk_b2_tail", 32'(ot_xy), 32'd0);
    send(1'b0, 1'b1, 16'h0000, 2'd1);
    check("pk_tail_port", 32'(port_xy), 32'd1);
    check("pk_tail_flag", 32'(ot_xy), 32'd1);
    check("pk_no_err",    32'(err_xy), 32'd0);

    // Body in IDLE: sticky error, forwarded on the latched route
    send(1'b0, 1'b0, 16'h0000, 2'd0);
    check("idle_body_err",  32'(err_xy), 32'd1);
    check("idle_body_port", 32'(port_xy), 32'd1);
    repeat (2) @(posedge clk); #1;
    check("err_sticky", 32'(err_xy), 32'd1);

    // Asynchronous reset mid-packet clears outputs without an edge
    send(1'b1, 1'b0, 16'h0042, 2'd1);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_valid", 32'(ov_xy), 32'd0);
    check("arst_port",  32'(port_xy), 32'd0);
    check("arst_ovch",  32'(ovch_xy), 32'd0);
    check("arst_err",   32'(err_xy), 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Head while in PKT: error and a fresh route
    send(1'b1, 1'b0, 16'h0015, 2'd0);
    check("pkt_start_err",  32'(err_xy), 32'd0);
    send(1'b1, 1'b0, 16'h0042, 2'd0);
    check("head_in_pkt_err",  32'(err_xy), 32'd1);
    check("head_in_pkt_port", 32'(port_xy), 32'd2);
    send(1'b0, 1'b1, 16'h0000, 2'd0);
    check("head_in_pkt_tail", 32'(port_xy), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
